// File: rtl/core_types_pkg.sv
// Shared core types: decoder control bundle, opcode/funct7 encodings and ALU helper.
package core_types_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct7 values that are legal for OP / shift-immediate; anything else is illegal
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_t;

   typedef enum logic [3:0] {
      BR_NONE = 4'd0,
      BR_EQ   = 4'd1,
      BR_NE   = 4'd2,
      BR_LT   = 4'd3,
      BR_GE   = 4'd4,
      BR_LTU  = 4'd5,
      BR_GEU  = 4'd6,
      BR_JAL  = 4'd7,
      BR_JALR = 4'd8
   } branch_t;

   // aluImm_m: B operand = imm; aluPc_m: A operand = PC; wbPc_m: write back PC+4
   typedef struct packed {
      logic [31:0] imm;
      alu_op_t     alu_codes;
      logic [2:0]  func3;
      branch_t     branch_type;
      logic        Wmem;
      logic        Wreg;
      logic        isLoad;
      logic        aluImm_m;
      logic        aluPc_m;
      logic        wbPc_m;
      logic        Rmem;
   } decoder_out_t;

   function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle, register
// indices and illegal/mul-div flags.
module decode_comb
   import core_types_pkg::*;
#(
   parameter bit EN_M = 1'b0
) (
   input  logic [31:0]  i_instr,
   output decoder_out_t o_ctrl,
   output logic [4:0]   o_rs1,
   output logic [4:0]   o_rs2,
   output logic [4:0]   o_rd,
   output logic         o_illegal,
   output logic         o_muldiv
);

   logic [6:0]   w_opc;
   logic [2:0]   w_f3;
   logic [6:0]   w_f7;
   logic [31:0]  w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
   decoder_out_t w_ctrl;
   logic         w_illegal;
   logic         w_muldiv;

   assign w_opc = i_instr[6:0];
   assign w_f3  = i_instr[14:12];
   assign w_f7  = i_instr[31:25];

   assign o_rd  = i_instr[11:7];
   assign o_rs1 = i_instr[19:15];
   assign o_rs2 = i_instr[24:20];

   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
   assign w_imm_u = {i_instr[31:12], 12'h000};
   assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

   always_comb begin
      w_ctrl             = '0;
      w_ctrl.func3       = w_f3;
      w_ctrl.alu_codes   = ALU_ADD;
      w_ctrl.branch_type = BR_NONE;
      w_illegal          = (i_instr[1:0] != 2'b11);
      w_muldiv           = 1'b0;

      case (w_opc)
         OPC_LUI: begin
            w_ctrl.imm       = w_imm_u;
            w_ctrl.Wreg      = 1'b1;
            w_ctrl.aluImm_m  = 1'b1;
            w_ctrl.alu_codes = ALU_PASSB;
         end
         OPC_AUIPC: begin
            w_ctrl.imm      = w_imm_u;
            w_ctrl.Wreg     = 1'b1;
            w_ctrl.aluImm_m = 1'b1;
            w_ctrl.aluPc_m  = 1'b1;
         end
         OPC_OPIMM: begin
            w_ctrl.imm       = w_imm_i;
            w_ctrl.Wreg      = 1'b1;
            w_ctrl.aluImm_m  = 1'b1;
            w_ctrl.alu_codes = alu_from_f3(w_f3, 1'b0);
            if (w_f3 == 3'b001 && w_f7 != F7_BASE) begin
               w_illegal = 1'b1;
            end
            if (w_f3 == 3'b101) begin
               if (w_f7 == F7_ALT)       w_ctrl.alu_codes = ALU_SRA;
               else if (w_f7 != F7_BASE) w_illegal = 1'b1;
            end
         end
         OPC_OP: begin
            w_ctrl.Wreg = 1'b1;
            if (w_f7 == F7_BASE) begin
               w_ctrl.alu_codes = alu_from_f3(w_f3, 1'b0);
            end else if (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
               w_ctrl.alu_codes = alu_from_f3(w_f3, 1'b1);
            end else if (EN_M && w_f7 == F7_MULDIV) begin
               // the mul/div unit keys off func3; alu_codes stays ADD
               w_muldiv = 1'b1;
            end else begin
               w_illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            w_ctrl.imm      = w_imm_i;
            w_ctrl.Wreg     = 1'b1;
            w_ctrl.aluImm_m = 1'b1;
            w_ctrl.isLoad   = 1'b1;
            w_ctrl.Rmem     = 1'b1;
            if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111) w_illegal = 1'b1;
         end
         OPC_STORE: begin
            w_ctrl.imm      = w_imm_s;
            w_ctrl.Wmem     = 1'b1;
            w_ctrl.aluImm_m = 1'b1;
            if (w_f3 > 3'b010) w_illegal = 1'b1;
         end
         OPC_JAL: begin
            w_ctrl.imm         = w_imm_j;
            w_ctrl.Wreg        = 1'b1;
            w_ctrl.aluImm_m    = 1'b1;
            w_ctrl.aluPc_m     = 1'b1;
            w_ctrl.wbPc_m      = 1'b1;
            w_ctrl.branch_type = BR_JAL;
         end
         OPC_JALR: begin
            w_ctrl.imm         = w_imm_i;
            w_ctrl.Wreg        = 1'b1;
            w_ctrl.aluImm_m    = 1'b1;
            w_ctrl.wbPc_m      = 1'b1;
            w_ctrl.branch_type = BR_JALR;
            if (w_f3 != 3'b000) w_illegal = 1'b1;
         end
         OPC_BRANCH: begin
            w_ctrl.imm       = w_imm_b;
            w_ctrl.alu_codes = ALU_SUB;
            case (w_f3)
               3'b000:  w_ctrl.branch_type = BR_EQ;
               3'b001:  w_ctrl.branch_type = BR_NE;
               3'b100:  w_ctrl.branch_type = BR_LT;
               3'b101:  w_ctrl.branch_type = BR_GE;
               3'b110:  w_ctrl.branch_type = BR_LTU;
               3'b111:  w_ctrl.branch_type = BR_GEU;
               default: w_illegal = 1'b1;
            endcase
         end
         default: w_illegal = 1'b1;
      endcase

      // illegal encodings must not produce any architectural side effect
      if (w_illegal) begin
         w_ctrl       = '0;
         w_ctrl.func3 = w_f3;
         w_muldiv     = 1'b0;
      end
   end

   assign o_ctrl    = w_ctrl;
   assign o_illegal = w_illegal;
   assign o_muldiv  = w_muldiv;

endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: DEPTH-entry instruction queue from fetch, combinational
// decode of the head, and a registered handshaked result toward execute.
module decode_stage
   import core_types_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter bit EN_M  = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [XLEN-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output decoder_out_t               out_ctrl,
   output logic [4:0]                 out_rs1,
   output logic [4:0]                 out_rs2,
   output logic [4:0]                 out_rd,
   output logic [XLEN-1:0]            out_pc,
   output logic                       out_illegal,
   output logic                       out_muldiv,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);

   logic [31:0]     r_iq [DEPTH];
   logic [XLEN-1:0] r_pq [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_count;

   logic            r_out_valid;
   decoder_out_t    r_ctrl;
   logic [4:0]      r_rs1, r_rs2, r_rd;
   logic [XLEN-1:0] r_pc;
   logic            r_illegal, r_muldiv;

   logic            w_push, w_pop;
   decoder_out_t    w_ctrl;
   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic            w_illegal, w_muldiv;

   // full check only: a pop in the same cycle never makes room for a push
   assign in_ready = rst_n && (r_count != CNT_FULL);
   assign w_push   = in_valid && in_ready;
   assign w_pop    = (r_count != '0) && (!r_out_valid || out_ready);

   decode_comb #(
      .EN_M (EN_M)
   ) u_dec (
      .i_instr   (r_iq[r_rptr]),
      .o_ctrl    (w_ctrl),
      .o_rs1     (w_rs1),
      .o_rs2     (w_rs2),
      .o_rd      (w_rd),
      .o_illegal (w_illegal),
      .o_muldiv  (w_muldiv)
   );

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_iq[r_wptr] <= in_instr;
         r_pq[r_wptr] <= in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
         r_ctrl      <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rd        <= '0;
         r_pc        <= '0;
         r_illegal   <= 1'b0;
         r_muldiv    <= 1'b0;
      end else if (flush) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_pop) begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_ctrl;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_pc        <= r_pq[r_rptr];
            r_illegal   <= w_illegal;
            r_muldiv    <= w_muldiv;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_ctrl    = r_ctrl;
   assign out_rs1     = r_rs1;
   assign out_rs2     = r_rs2;
   assign out_rd      = r_rd;
   assign out_pc      = r_pc;
   assign out_illegal = r_illegal;
   assign out_muldiv  = r_muldiv;
   assign occupancy   = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Drives two decode_stage copies (EN_M=0 and EN_M=1) with shared stimulus and
// checks both against a queue-level model and an ISA-rule decoder.
module tb_decode_stage;
   import core_types_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;

   logic         ir0, ov0, ill0, md0, ir1, ov1, ill1, md1;
   decoder_out_t ct0, ct1;
   logic [4:0]   rs1_0, rs2_0, rd0, rs1_1, rs2_1, rd1;
   logic [31:0]  pc0, pc1;
   logic [2:0]   occ0, occ1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   bit   mov = 1'b0;
   ent_t moe;

   logic [6:0] opcs [9] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011,
                            7'b0000011, 7'b0100011, 7'b1101111, 7'b1100111,
                            7'b1100011};
   alu_op_t alu_tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   branch_t br_tab  [8] = '{BR_EQ, BR_NE, BR_NONE, BR_NONE,
                            BR_LT, BR_GE, BR_LTU, BR_GEU};

   decode_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov0), .out_ready(out_ready),
      .out_ctrl(ct0), .out_rs1(rs1_0), .out_rs2(rs2_0), .out_rd(rd0), .out_pc(pc0),
      .out_illegal(ill0), .out_muldiv(md0), .occupancy(occ0));

   decode_stage #(.XLEN(32), .DEPTH(DEPTH), .EN_M(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov1), .out_ready(out_ready),
      .out_ctrl(ct1), .out_rs1(rs1_1), .out_rs2(rs2_1), .out_rd(rd1), .out_pc(pc1),
      .out_illegal(ill1), .out_muldiv(md1), .occupancy(occ1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ISA-level reference decode built from the instruction-set rules
   function automatic void ref_dec(input logic [31:0] w, input bit en_m,
                                   output decoder_out_t c, output logic ill,
                                   output logic md);
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      int         s;
      opc = w[6:0];
      f3  = w[14:12];
      f7  = w[31:25];
      s   = $signed(w);
      c = '0;
      c.func3 = f3;
      ill = (w[1:0] != 2'b11);
      md = 1'b0;
      if (opc == 7'b0110111) begin
         c.imm = w & 32'hFFFFF000; c.Wreg = 1; c.aluImm_m = 1; c.alu_codes = ALU_PASSB;
      end else if (opc == 7'b0010111) begin
         c.imm = w & 32'hFFFFF000; c.Wreg = 1; c.aluImm_m = 1; c.aluPc_m = 1;
      end else if (opc == 7'b0010011) begin
         c.imm = 32'(s >>> 20); c.Wreg = 1; c.aluImm_m = 1; c.alu_codes = alu_tab[f3];
         if (f3 == 1 && f7 != 0) ill = 1;
         if (f3 == 5 && f7 == 7'h20) c.alu_codes = ALU_SRA;
         if (f3 == 5 && f7 != 0 && f7 != 7'h20) ill = 1;
      end else if (opc == 7'b0110011) begin
         c.Wreg = 1;
         if (f7 == 0) c.alu_codes = alu_tab[f3];
         else if (f7 == 7'h20 && f3 == 0) c.alu_codes = ALU_SUB;
         else if (f7 == 7'h20 && f3 == 5) c.alu_codes = ALU_SRA;
         else if (f7 == 7'h01 && en_m) md = 1;
         else ill = 1;
      end else if (opc == 7'b0000011) begin
         c.imm = 32'(s >>> 20); c.Wreg = 1; c.aluImm_m = 1; c.isLoad = 1; c.Rmem = 1;
         if (f3 == 3 || f3 == 6 || f3 == 7) ill = 1;
      end else if (opc == 7'b0100011) begin
         c.imm = 32'((s >>> 25) <<< 5) | 32'(w[11:7]); c.Wmem = 1; c.aluImm_m = 1;
         if (f3 > 2) ill = 1;
      end else if (opc == 7'b1101111) begin
         c.imm = 32'((s >>> 31) <<< 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11)
               | (32'(w[30:21]) << 1);
         c.Wreg = 1; c.aluImm_m = 1; c.aluPc_m = 1; c.wbPc_m = 1; c.branch_type = BR_JAL;
      end else if (opc == 7'b1100111) begin
         c.imm = 32'(s >>> 20); c.Wreg = 1; c.aluImm_m = 1; c.wbPc_m = 1;
         c.branch_type = BR_JALR;
         if (f3 != 0) ill = 1;
      end else if (opc == 7'b1100011) begin
         c.imm = 32'((s >>> 31) <<< 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5)
               | (32'(w[11:8]) << 1);
         c.alu_codes = ALU_SUB; c.branch_type = br_tab[f3];
         if (f3 == 2 || f3 == 3) ill = 1;
      end else begin
         ill = 1;
      end
      if (ill) begin
         c = '0;
         c.func3 = f3;
         md = 1'b0;
      end
   endfunction

   task automatic chk_out(input string p, input bit en_m, input decoder_out_t ct,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] pc, input logic ill, input logic md);
      decoder_out_t ec;
      logic         eill, emd;
      ref_dec(moe.instr, en_m, ec, eill, emd);
      chk({p, "_ctrl"}, ct, ec);
      chk({p, "_rs1"}, rs1, moe.instr[19:15]);
      chk({p, "_rs2"}, rs2, moe.instr[24:20]);
      chk({p, "_rd"}, rd, moe.instr[11:7]);
      chk({p, "_pc"}, pc, moe.pc);
      chk({p, "_illegal"}, ill, eill);
      chk({p, "_muldiv"}, md, emd);
   endtask

   // advance the model by one edge, clock the DUTs, then compare
   task automatic tick();
      bit   push, pop;
      ent_t e;
      if (!rst_n || flush) begin
         mq.delete();
         mov = 1'b0;
      end else begin
         push = in_valid && (mq.size() < DEPTH);
         pop  = (mq.size() > 0) && (!mov || out_ready);
         if (pop) begin
            moe = mq.pop_front();
            mov = 1'b1;
         end else if (out_ready) begin
            mov = 1'b0;
         end
         if (push) begin
            e.instr = in_instr;
            e.pc    = in_pc;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      chk("occ0", occ0, mq.size());
      chk("occ1", occ1, mq.size());
      chk("in_ready0", ir0, rst_n && (mq.size() < DEPTH));
      chk("in_ready1", ir1, rst_n && (mq.size() < DEPTH));
      chk("out_valid0", ov0, mov);
      chk("out_valid1", ov1, mov);
      if (mov) begin
         chk_out("m0", 1'b0, ct0, rs1_0, rs2_0, rd0, pc0, ill0, md0);
         chk_out("m1", 1'b1, ct1, rs1_1, rs2_1, rd1, pc1, ill1, md1);
      end
   endtask

   task automatic push_one(input logic [31:0] w, input logic [31:0] pc);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = w;
      in_pc     = pc;
      tick();
      in_valid  = 1'b0;
      tick();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int          k;
      w = $urandom;
      k = $urandom_range(0, 9);
      if (k < 9) w[6:0] = opcs[k];
      if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) begin
         case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            2:       w[31:25] = 7'h01;
            default: ;
         endcase
      end
      return w;
   endfunction

   initial begin
      // reset held for two edges
      tick();
      tick();
      chk("rst_ctrl", ct0, '0);
      chk("rst_pc", pc0, 0);
      chk("rst_rd", rd0, 0);
      chk("rst_ill", ill0, 0);
      chk("rst_md", md1, 0);

      // ADDI x1, x0, 5 at 0x100
      rst_n = 1'b1;
      push_one(32'h00500093, 32'h100);
      chk("addi_valid", ov0, 1);
      chk("addi_rd", rd0, 5'd1);
      chk("addi_imm", ct0.imm, 32'd5);
      chk("addi_wreg", ct0.Wreg, 1);
      chk("addi_aluimm", ct0.aluImm_m, 1);
      chk("addi_pc", pc0, 32'h100);
      chk("addi_ill", ill0, 0);
      tick();

      // backpressure: five accepted, sixth refused
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_instr = rand_instr();
         in_pc    = 32'h200 + 32'(4 * i);
         tick();
      end
      chk("full_occ", occ0, 3'd4);
      chk("full_ready", ir0, 0);
      chk("full_head_pc", pc0, 32'h200);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      // pointer wrap with back-to-back traffic
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_instr = rand_instr();
         in_pc    = 32'h400 + 32'(4 * i);
         tick();
         chk("wrap_occ_le1", occ0 <= 3'd1, 1);
      end
      in_valid = 1'b0;
      tick();
      tick();

      // flush with three queued, one registered and a push in flight
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h00000013 | (32'(i + 1) << 7);
         in_pc    = 32'h800 + 32'(4 * i);
         tick();
      end
      chk("pre_flush_occ", occ0, 3'd3);
      chk("pre_flush_valid", ov0, 1);
      flush    = 1'b1;
      in_instr = 32'h00700393;
      in_pc    = 32'h900;
      tick();
      chk("flush_valid", ov0, 0);
      chk("flush_occ", occ0, 3'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // illegal encodings
      push_one(32'h00000000, 32'hA00);
      chk("ill_zero", ill0, 1);
      chk("ill_zero_wreg", ct0.Wreg, 0);
      push_one(32'h00002063, 32'hA04);
      chk("ill_br", ill0, 1);
      chk("ill_br_wmem", ct0.Wmem, 0);
      chk("ill_br_pc", pc0, 32'hA04);
      push_one(32'h00007003, 32'hA08);
      chk("ill_ld", ill1, 1);
      chk("ill_ld_rmem", ct1.Rmem, 0);
      chk("ill_ld_wreg", ct1.Wreg, 0);

      // MUL x3, x1, x2
      push_one(32'h022081B3, 32'hB00);
      chk("mul_m1_md", md1, 1);
      chk("mul_m1_ill", ill1, 0);
      chk("mul_m1_rd", rd1, 5'd3);
      chk("mul_m1_wreg", ct1.Wreg, 1);
      chk("mul_m0_ill", ill0, 1);
      chk("mul_m0_md", md0, 0);

      // randomized traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_instr  = rand_instr();
         in_pc     = $urandom & 32'hFFFFFFFC;
         tick();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Buffered, handshaked instruction-decode stage between fetch and execute.
- Accepts {instruction, PC} from fetch into a DEPTH-entry queue.
- Decodes the queue head combinationally, then registers the result (control bundle, register indices, PC, illegal/mul-div flags) toward execute.
- Beyond a plain combinational decoder, it adds buffering, backpressure, flush, illegal-instruction detection and an optional M-extension mode.

Parameters:
- XLEN, 32, PC width in bits.
- DEPTH, 4, instruction-queue entries; power of two, at least 2.
- EN_M, 0, 1 = decode RV32M (OP with f7 = 0000001) as legal mul/div; 0 = such encodings are illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  discard all queued and registered instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept (not full).
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded result valid.
- out_ready  in  1  execute accepts the result.
- out_ctrl  out  decoder_out_t  control bundle (imm, alu_codes, func3, branch_type, Wmem, Wreg, isLoad, mux selects, Rmem).
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_illegal  out  1  instruction is illegal.
- out_muldiv  out  1  legal RV32M instruction (EN_M=1 only).
- occupancy  out  $clog2(DEPTH)+1  queue entry count.

Behaviour:
- Reset: the rst_n-low edge clears the queue pointers and count; out_valid, out_illegal, out_muldiv are 0; out_ctrl, out_pc and register indices are all-zero; in_ready is 0 while rst_n is low.
- Queue push: in_valid && in_ready at an edge. in_ready = (count != DEPTH). There is no push-when-full, even if a pop happens in the same cycle.
- Pointers: log2(DEPTH) bits, natural wrap. Count is one bit wider; same-cycle push and pop leave the count unchanged.
- Output register load condition: queue non-empty && (!out_valid || out_ready). The head is popped and its decode is registered.
- Output register hold: if out_valid && !out_ready, all out_* signals hold stable.
- Output register drain: if out_ready and the queue is empty, out_valid drops to 0.
- Latency: an instruction pushed at edge N appears with out_valid=1 after edge N+1 (queue empty, register free).
- Throughput: one instruction per cycle sustained.
- flush: highest priority after reset. At that edge the count becomes 0, pointers reset, out_valid becomes 0, and any same-cycle push is dropped. in_ready stays combinational (flush does not gate it).
- Decode fields: opcode = instr[6:0], rd = [11:7], func3 = [14:12], rs1 = [19:15], rs2 = [24:20], f7 bit = instr[30].
- Immediate formats: sign-extended per U/I/S/B/J type, using the same per-opcode signal groups as the existing decoder.
- Illegal when any of:
  - instr[1:0] != 11
  - opcode is outside {LUI, AUIPC, OPIMM, OP, LOAD, STORE, JAL, JALR, BRANCH}
  - OP with instr[31:25] not in {0000000, 0100000, 0000001 if EN_M}; 0100000 is legal only for func3 000/101
  - OPIMM with func3=001 and instr[31:25] != 0, or func3=101 and instr[31:25] not in {0000000, 0100000}
  - LOAD with func3 in {011, 110, 111}
  - STORE with func3 > 010
  - BRANCH with func3 in {010, 011}
  - JALR with func3 != 000
- Illegal result: out_illegal=1; Wreg, Wmem, Rmem, isLoad = 0; branch_type = none; alu_codes = ADD; imm = 0. out_pc is still valid, for trap use.
- M-extension: with EN_M=1, OP with instr[31:25]=0000001 gives out_muldiv=1, Wreg=1, func3 passed through, and alu_codes = ADD (unused by the ALU).

Decomposition:
- Shared package core_types_pkg additions: decoder_out_t (existing), an illegal-encoding f7 constant set, F7_MULDIV = 7'b0000001, and BR_NONE.
- Sub-module decode_comb: purely combinational instr -> {ctrl, rs1, rs2, rd, illegal, muldiv}, parameterised by EN_M.
- Queue and output register stay inline in decode_stage.

Test Plan:
- Reset held 2 cycles, then push ADDI x1, x0, 5 (0x00500093) at PC 0x100. Required: out_valid after 1 edge; rd=1, imm=5, Wreg=1, aluImm_m=1, out_pc=0x100, out_illegal=0.
- out_ready=0, push 5 instructions with DEPTH=4. Required: 1 instruction in the output register; occupancy reaches 4 and in_ready=0; the 6th is not accepted. Release out_ready and check in-order drain, one per cycle.
- Pointer wrap: run 10 back-to-back pushes with out_ready=1. Required: outputs appear in order with correct PCs; occupancy never exceeds 1.
- flush asserted while occupancy=3, out_valid=1, and in_valid=1. Required: next cycle out_valid=0 and occupancy=0; the pushed instruction never appears.
- Illegal cases: 0x00000000 (bits[1:0]=00), BRANCH func3=010 (0x00002063) and LOAD func3=111. Required: out_illegal=1 and Wreg=Wmem=Rmem=0 for each.
- MUL x3, x1, x2 (0x022081B3). With EN_M=1: out_muldiv=1, out_illegal=0, rd=3. With EN_M=0: out_illegal=1, out_muldiv=0.
